// File: rtl/sub_serial_4b_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sub_serial_4b_pkg
//  Description : Shared definitions for the bit-serial subtractor: FSM state
//                encoding and the default operand width.
//  Revision    : 1.0 - initial release
// ============================================================================
package sub_serial_4b_pkg;

    // Default operand/result width of the serial subtractor.
    localparam int c_default_width = 4;

    // Controller states, explicitly encoded so the reset value is all-zero.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : sub_serial_4b_pkg
`default_nettype wire

// File: rtl/sub_serial_4b_fs_1b.sv
`default_nettype none
// ============================================================================
//  Module      : fs_1b
//  Description : 1-bit full subtractor, pure gate-level boolean logic.
//                D    = A ^ B ^ Bin
//                Bout = (~A & B) | (~A & Bin) | (B & Bin)
//  Ports       : A, B, Bin  - minuend bit, subtrahend bit, borrow-in
//                D, Bout    - difference bit, borrow-out
//  Revision    : 1.0 - initial release
// ============================================================================
module fs_1b (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic D,
    output logic Bout
);

    assign D    = A ^ B ^ Bin;
    assign Bout = (~A & B) | (~A & Bin) | (B & Bin);

endmodule : fs_1b
`default_nettype wire

// File: rtl/sub_serial_4b.sv
`default_nettype none
// ============================================================================
//  Module      : sub_serial_4b
//  Description : Bit-serial subtractor, D = A - B - Bin, processed LSB first
//                through one fs_1b cell and a registered borrow. A start
//                accepted while not busy loads the operands; WIDTH SHIFT
//                cycles later the result is registered and done pulses.
//  Ports       : clk, rst (async, active-high)
//                start, A[WIDTH], B[WIDTH], Bin   - request and operands
//                busy, done, D[WIDTH], Bout       - status and result
//                OVF (only with SUB_SERIAL_OVF_EN) - signed overflow flag
//  Options     : define SUB_SERIAL_OVF_EN to add the OVF output.
//  Revision    : 1.0 - initial release
// ============================================================================
module sub_serial_4b
    import sub_serial_4b_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout
`ifdef SUB_SERIAL_OVF_EN
    ,
    output logic             OVF
`endif
);

    localparam int                c_cnt_w    = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    state_t             r_state_q, w_state_d;
    logic [WIDTH-1:0]   r_a_sh_q,  w_a_sh_d;
    logic [WIDTH-1:0]   r_b_sh_q,  w_b_sh_d;
    logic [WIDTH-1:0]   r_d_sh_q,  w_d_sh_d;
    logic               r_brw_q,   w_brw_d;
    logic [c_cnt_w-1:0] r_cnt_q,   w_cnt_d;
    logic               r_busy_q,  w_busy_d;
    logic               r_done_q,  w_done_d;
    logic [WIDTH-1:0]   r_d_q,     w_d_d;
    logic               r_bout_q,  w_bout_d;
`ifdef SUB_SERIAL_OVF_EN
    logic               r_ovf_q,   w_ovf_d;
`endif

    logic w_fs_d;
    logic w_fs_bout;

    fs_1b u_fs_1b (
        .A    (r_a_sh_q[0]),
        .B    (r_b_sh_q[0]),
        .Bin  (r_brw_q),
        .D    (w_fs_d),
        .Bout (w_fs_bout)
    );

    always_comb begin
        w_state_d = r_state_q;
        w_a_sh_d  = r_a_sh_q;
        w_b_sh_d  = r_b_sh_q;
        w_d_sh_d  = r_d_sh_q;
        w_brw_d   = r_brw_q;
        w_cnt_d   = r_cnt_q;
        w_busy_d  = 1'b0;
        w_done_d  = 1'b0;
        w_d_d     = r_d_q;
        w_bout_d  = r_bout_q;
`ifdef SUB_SERIAL_OVF_EN
        w_ovf_d   = r_ovf_q;
`endif
        case (r_state_q)
            // DONE accepts a new start exactly like IDLE (back-to-back).
            IDLE, DONE: begin
                if (start) begin
                    w_a_sh_d  = A;
                    w_b_sh_d  = B;
                    w_brw_d   = Bin;
                    w_cnt_d   = '0;
                    w_state_d = SHIFT;
                    w_busy_d  = 1'b1;
                end else begin
                    w_state_d = IDLE;
                end
            end
            SHIFT: begin
                // Difference bits enter at the MSB end, so after WIDTH
                // shifts the first (LSB) bit has reached position 0.
                w_a_sh_d = {1'b0, r_a_sh_q[WIDTH-1:1]};
                w_b_sh_d = {1'b0, r_b_sh_q[WIDTH-1:1]};
                w_d_sh_d = {w_fs_d, r_d_sh_q[WIDTH-1:1]};
                w_brw_d  = w_fs_bout;
                w_cnt_d  = r_cnt_q + c_cnt_one;
                if (r_cnt_q == c_cnt_last) begin
                    w_state_d = DONE;
                    w_done_d  = 1'b1;
                    w_d_d     = {w_fs_d, r_d_sh_q[WIDTH-1:1]};
                    w_bout_d  = w_fs_bout;
`ifdef SUB_SERIAL_OVF_EN
                    // On the last bit the shifters hold the captured MSBs.
                    w_ovf_d   = (r_a_sh_q[0] ^ r_b_sh_q[0]) & (w_fs_d ^ r_a_sh_q[0]);
`endif
                end else begin
                    w_busy_d = 1'b1;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= IDLE;
            r_a_sh_q  <= '0;
            r_b_sh_q  <= '0;
            r_d_sh_q  <= '0;
            r_brw_q   <= 1'b0;
            r_cnt_q   <= '0;
            r_busy_q  <= 1'b0;
            r_done_q  <= 1'b0;
            r_d_q     <= '0;
            r_bout_q  <= 1'b0;
`ifdef SUB_SERIAL_OVF_EN
            r_ovf_q   <= 1'b0;
`endif
        end else begin
            r_state_q <= w_state_d;
            r_a_sh_q  <= w_a_sh_d;
            r_b_sh_q  <= w_b_sh_d;
            r_d_sh_q  <= w_d_sh_d;
            r_brw_q   <= w_brw_d;
            r_cnt_q   <= w_cnt_d;
            r_busy_q  <= w_busy_d;
            r_done_q  <= w_done_d;
            r_d_q     <= w_d_d;
            r_bout_q  <= w_bout_d;
`ifdef SUB_SERIAL_OVF_EN
            r_ovf_q   <= w_ovf_d;
`endif
        end
    end

    assign busy = r_busy_q;
    assign done = r_done_q;
    assign D    = r_d_q;
    assign Bout = r_bout_q;
`ifdef SUB_SERIAL_OVF_EN
    assign OVF  = r_ovf_q;
`endif

endmodule : sub_serial_4b
`default_nettype wire

// File: tb/tb_sub_serial_4b.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sub_serial_4b
//  Description : Self-checking bench for sub_serial_4b (WIDTH=4). Results are
//                matched against a queue of expected values pushed at issue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sub_serial_4b;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Bin;
    logic         busy;
    logic         done;
    logic [W-1:0] D;
    logic         Bout;
`ifdef SUB_SERIAL_OVF_EN
    logic         OVF;
`endif

    sub_serial_4b #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .busy  (busy),
        .done  (done),
        .D     (D),
        .Bout  (Bout)
`ifdef SUB_SERIAL_OVF_EN
        ,
        .OVF   (OVF)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] d;
        logic         bout;
        logic         ovf;
    } vec_t;

    typedef struct {
        logic [W-1:0] d;
        logic         bout;
        logic         ovf;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("D", 32'(D), 32'(e.d));
                check("Bout", 32'(Bout), 32'(e.bout));
`ifdef SUB_SERIAL_OVF_EN
                check("OVF", 32'(OVF), 32'(e.ovf));
`endif
            end
        end
    end

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        exp_t        e;
        logic [W:0]  full;
        full   = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        e.d    = full[W-1:0];
        e.bout = full[W];
        e.ovf  = (a[W-1] != b[W-1]) && (e.d[W-1] != a[W-1]);
        return e;
    endfunction

    // Called at a negedge; waits for not-busy, drives a one-cycle start.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin, input exp_t e);
        int guard;
        guard = 0;
        while (busy !== 1'b0) begin
            @(negedge clk);
            guard++;
            if (guard > 50) begin
                check("issue_timeout", 32'd1, 32'd0);
                return;
            end
        end
        A = a; B = b; Bin = bin; start = 1'b1;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb_q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (sb_q.size() != 0) begin
            check("drain_timeout", 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    vec_t vecs[8];

    initial begin
        exp_t e;
        int   ndone;
        logic [W-1:0] ra, rb;
        logic         rbin;

        vecs[0] = '{4'b1001, 4'b0011, 1'b0, 4'b0110, 1'b0, 1'b1};
        vecs[1] = '{4'b0011, 4'b1001, 1'b0, 4'b1010, 1'b1, 1'b1};
        vecs[2] = '{4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0};
        vecs[3] = '{4'b0111, 4'b1111, 1'b0, 4'b1000, 1'b1, 1'b1};
        vecs[4] = '{4'b1111, 4'b0000, 1'b0, 4'b1111, 1'b0, 1'b0};
        vecs[5] = '{4'b0101, 4'b0101, 1'b1, 4'b1111, 1'b1, 1'b0};
        vecs[6] = '{4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1};
        vecs[7] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0};

        rst = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_D", 32'(D), 32'd0);
        check("rst_Bout", 32'(Bout), 32'd0);
`ifdef SUB_SERIAL_OVF_EN
        check("rst_OVF", 32'(OVF), 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Latency and busy window: busy on negedges 1..4, done on negedge 5.
        A = 4'b1001; B = 4'b0011; Bin = 1'b0; start = 1'b1;
        e = '{4'b0110, 1'b0, 1'b1};
        sb_q.push_back(e);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0;
            check("lat_busy", 32'(busy), (k <= 4) ? 32'd1 : 32'd0);
            check("lat_done", 32'(done), (k == 5) ? 32'd1 : 32'd0);
        end
        repeat (2) @(negedge clk);
        check("hold_D", 32'(D), 32'b0110);
        check("hold_done_low", 32'(done), 32'd0);

        // Table-driven vectors; issue() naturally starts in the DONE cycle.
        for (int i = 0; i < 8; i++) begin
            e = '{vecs[i].d, vecs[i].bout, vecs[i].ovf};
            issue(vecs[i].a, vecs[i].b, vecs[i].bin, e);
        end
        drain();

        // Start during SHIFT is ignored; start in the DONE cycle is accepted.
        A = 4'b1001; B = 4'b0011; Bin = 1'b0; start = 1'b1;
        e = '{4'b0110, 1'b0, 1'b1};
        sb_q.push_back(e);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 2) begin
                A = 4'b1111; B = 4'b0000; start = 1'b1;
            end
            if (k == 5) begin
                check("ign_done", 32'(done), 32'd1);
                A = 4'b0011; B = 4'b1001; Bin = 1'b0; start = 1'b1;
                e = '{4'b1010, 1'b1, 1'b1};
                sb_q.push_back(e);
            end
        end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0;
            check("b2b_busy", 32'(busy), (k <= 4) ? 32'd1 : 32'd0);
            check("b2b_done", 32'(done), (k == 5) ? 32'd1 : 32'd0);
        end
        drain();

        // Reset in the second SHIFT cycle clears outputs immediately.
        A = 4'b0101; B = 4'b0010; Bin = 1'b0; start = 1'b1;
        sb_q.push_back(model(4'b0101, 4'b0010, 1'b0));
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_D", 32'(D), 32'd0);
        check("mid_rst_Bout", 32'(Bout), 32'd0);
        void'(sb_q.pop_back());
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("no_done_after_rst", 32'(ndone), 32'd0);

        issue(4'b0101, 4'b0010, 1'b0, model(4'b0101, 4'b0010, 1'b0));
        drain();

        // Random vectors against the arithmetic model.
        for (int i = 0; i < 12; i++) begin
            ra   = W'($urandom_range(0, 15));
            rb   = W'($urandom_range(0, 15));
            rbin = 1'($urandom_range(0, 1));
            issue(ra, rb, rbin, model(ra, rb, rbin));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_sub_serial_4b
`default_nettype wire
